mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the I/D cache memory-port arbiter:
//   - default line-address and cache-line widths
//   - FSM state encoding
//   - grant selection helper for the alternating-priority build
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    // Returns 1 when D should win. An uncontested requester always wins;
    // on contention the side that did not take the previous grant wins.
    function automatic logic rr_pick_d(input logic i_req,
                                       input logic d_req,
                                       input logic last_grant_d);
        return d_req && (!i_req || !last_grant_d);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an I-cache (line fills) and a D-cache
//   (line fills and write-backs). One transfer at a time:
//   IDLE -> grant -> I_BUSY/D_BUSY (command held until mem_ready) -> DONE
//   (one-cycle ready pulse to the granted side) -> IDLE.
//
//   Build option: ARB_ROUND_ROBIN_EN
//     undefined : fixed priority, D wins over I on every grant
//     defined   : contested grants alternate; D wins the first one
//
//   Handshake: each cache raises its request and holds it (with address /
//   data stable) until it sees its ready pulse; ready is high for exactly
//   one cycle and the returned line is only meaningful in that cycle. The
//   memory sees a command held from the first busy cycle through the cycle
//   in which it answers with a single-cycle mem_ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_read, i_addr      I-cache fill request
//   i_rdata, i_ready    I-cache returned line / completion pulse
//   d_read, d_write     D-cache fill / write-back request (write wins if both)
//   d_addr, d_wdata     D-cache line address / write-back data
//   d_rdata, d_ready    D-cache returned line / completion pulse
//   mem_read, mem_write shared memory port command (registered)
//   mem_addr, mem_wdata shared memory port address / write data (registered)
//   mem_rdata, mem_ready memory read data / one-cycle completion
//   state_dbg           current FSM state (arb_state_t encoding)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        state_dbg
);

    arb_state_t        state_q, state_d;
    logic              grant;
    logic              sel_d;
    logic              i_req, d_req;
    logic              busy;
    logic              grant_d_q;     // side owning the current transfer, 1 = D
    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

    assign i_req = i_read;
    assign d_req = d_read | d_write;
    assign busy  = (state_q == ST_I_BUSY) || (state_q == ST_D_BUSY);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_d_q;  // 0 = I took the last grant

    assign sel_d = rr_pick_d(i_req, d_req, last_grant_d_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d_q <= 1'b0;
        end else if (grant) begin
            last_grant_d_q <= sel_d;
        end
    end
`else
    assign sel_d = d_req;
`endif

    // Next-state logic. Grants happen only in IDLE, so a request still high
    // during DONE (the requester has not yet reacted to its ready pulse) is
    // never mistaken for a new one.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    grant   = 1'b1;
                    state_d = sel_d ? ST_D_BUSY : ST_I_BUSY;
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_d_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                grant_d_q   <= sel_d;
                addr_q      <= sel_d ? d_addr : i_addr;
                // d_write takes precedence if the D side asserts both
                mem_write_q <= sel_d & d_write;
                mem_read_q  <= sel_d ? ~d_write : 1'b1;
                if (sel_d) begin
                    wdata_q <= d_wdata;
                end
            end
            // mem_ready outside a busy state is stale and ignored
            if (busy && mem_ready) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                if (grant_d_q) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    i_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign i_ready   = (state_q == ST_DONE) && !grant_d_q;
    assign d_ready   = (state_q == ST_DONE) &&  grant_d_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign state_dbg = state_q;

endmodule
